apb_timer_nch: RTL
==================

# apb_timer_nch

Parametrised multi-channel APB down-counting timer, successor to the fixed two-channel timer top. It provides NUM_CH independent channels of CNT_W bits, each with free-running or user-reload mode, optional one-shot, per-channel interrupt mask and read-to-clear EOI. It also supports ETB start/stop control and a one-cycle ETB trigger pulse on expiry. It sits on the peripheral APB bus as a slave, and its `intr` lines go to the interrupt controller.

## Interface
- NUM_CH, 2, channel count, 1..8
- CNT_W, 32, counter/load width, 8..32
- pclk  in  1  APB and counter clock
- presetn  in  1  asynchronous active-low reset
- psel, penable, pwrite  in  1  APB3 control; zero wait states, no pready/pslverr
- paddr  in  8  byte address
- pwdata  in  32  write data
- prdata  out  32  read data; 0 when not a read access
- etb_trig_en_on  in  NUM_CH  one-cycle pulse, sets channel enable
- etb_trig_en_off  in  NUM_CH  one-cycle pulse, clears channel enable
- etb_trig  out  NUM_CH  one-cycle registered pulse on channel expiry
- intr  out  NUM_CH  level interrupt, raw & ~mask
- scan_mode  in  1  DFT only, no functional effect

## Operation
- Channel i registers at base 0x14*i:
  - +0x00 LOAD (RW, CNT_W bits)
  - +0x04 CURRENT (RO)
  - +0x08 CTRL (RW): bit0 EN, bit1 MODE (1 user-reload, 0 free-run), bit2 MASK, bit3 ONESHOT
  - +0x0C EOI (RO, read returns 0 and clears the channel raw flag)
  - +0x10 ISTAT (RO, raw & ~mask)
- Global registers:
  - 0xA0 INTSTAT (masked, bit per channel)
  - 0xA4 EOI_ALL (read clears all raw flags)
  - 0xA8 RAWSTAT
- Unmapped reads return 0; unmapped writes are ignored. Bits above CNT_W read 0.
- Writes take effect in the access phase (psel & penable & pwrite). EOI side effects happen in the read access phase only.
- EN rising, from APB or ETB: CURRENT loads LOAD on the next edge.
- While EN=1, each tick:
  - CURRENT != 0: decrement.
  - CURRENT == 0: expiry. Set raw flag, pulse etb_trig, reload LOAD (MODE=1) or all-ones (MODE=0). If ONESHOT=1, clear EN and hold at 0 instead of reloading.
- EN=0: CURRENT holds its value.
- A write to LOAD while running takes effect at the next reload only.
- Period in user mode is LOAD+1 ticks. LOAD=0 expires every tick.
- Simultaneous events:
  - etb_trig_en_off beats etb_trig_en_on.
  - An APB CTRL write beats both ETB inputs in the same cycle.
  - Expiry beats EOI clear: the flag stays set.

## Timing
- Reset: all registers, CURRENT, raw flags, etb_trig and intr are 0. prdata is combinational from paddr.
- APB write at cycle T: the register updates at the edge ending T. Counter action starts at T+1.
- Expiry at the edge with CURRENT==0: the raw flag, intr and etb_trig are visible in the next cycle. etb_trig lasts exactly one cycle.
- EOI read at cycle T: intr deasserts at T+1.
- Reset asserted mid-count: everything returns to reset values asynchronously, with no pulse emitted.

## Configuration
- TIMER_PRESCALER_EN defined: CTRL[15:8] is a per-channel PRESC register. A tick occurs every PRESC+1 pclk cycles. The prescaler counter clears on EN rising and on a CTRL write.
- Macro undefined: CTRL[15:8] reads 0 and ignores writes, and a tick occurs every pclk cycle.

## Structure
- Package apb_timer_pkg holds:
  - register offsets, channel stride 0x14 and global offsets
  - CTRL bit positions
  - the CTRL struct typedef
- Sub-module apb_timer_chan, instantiated NUM_CH times, holds one counter, its control, raw flag, trig and prescaler.
- The top holds APB decode, the read mux and the global registers.

## Test plan
- Ch0 LOAD=5, CTRL=0x3 (enable, user-reload) -> etb_trig[0] pulses every 6 cycles; CURRENT cycles 5..0; intr[0] rises 1 cycle after the first 0.
- Ch1 CTRL=0x1 (free-run), LOAD=3 -> first expiry after 4 ticks, then CURRENT=0xFFFFFFFF (CNT_W=32).
- ONESHOT: LOAD=2, CTRL=0x9 -> single expiry, EN reads 0, CURRENT stays 0, no second pulse.
- MASK=1 -> RAWSTAT bit set, INTSTAT and intr stay 0. An EOI read in the same cycle as expiry leaves the raw flag at 1.
- etb_trig_en_on and etb_trig_en_off pulsed together -> EN stays 0. etb_trig_en_on alone -> counter loads LOAD on the next edge.
- With TIMER_PRESCALER_EN, PRESC=3, LOAD=1 -> expiry every 8 pclk. Without the macro, CTRL[15:8] reads 0.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register map, CTRL bit positions and the CTRL struct shared
// by the multi-channel APB timer and its per-channel counter.
package apb_timer_pkg;

    // Per-channel register offsets; channel i lives at CH_STRIDE*i
    localparam logic [7:0] CH_STRIDE    = 8'h14;
    localparam logic [7:0] OFF_LOAD     = 8'h00;
    localparam logic [7:0] OFF_CURRENT  = 8'h04;
    localparam logic [7:0] OFF_CTRL     = 8'h08;
    localparam logic [7:0] OFF_EOI      = 8'h0C;
    localparam logic [7:0] OFF_ISTAT    = 8'h10;

    // Global registers
    localparam logic [7:0] ADDR_INTSTAT = 8'hA0;
    localparam logic [7:0] ADDR_EOI_ALL = 8'hA4;
    localparam logic [7:0] ADDR_RAWSTAT = 8'hA8;

    // CTRL bit positions
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_MODE_BIT    = 1;
    localparam int CTRL_MASK_BIT    = 2;
    localparam int CTRL_ONESHOT_BIT = 3;
    localparam int CTRL_PRESC_LSB   = 8;

    typedef struct packed {
        logic [7:0] presc;
        logic       oneshot;
        logic       mask;
        logic       mode;
        logic       en;
    } ctrl_t;

    // Absolute byte address of a per-channel register
    function automatic logic [7:0] chan_addr(input int ch, input logic [7:0] off);
        return 8'(ch * int'(CH_STRIDE)) + off;
    endfunction

    // Bus word -> CTRL fields
    function automatic ctrl_t ctrl_decode(input logic [31:0] w);
        ctrl_t c;
        c.en      = w[CTRL_EN_BIT];
        c.mode    = w[CTRL_MODE_BIT];
        c.mask    = w[CTRL_MASK_BIT];
        c.oneshot = w[CTRL_ONESHOT_BIT];
        c.presc   = w[CTRL_PRESC_LSB +: 8];
        return c;
    endfunction

    // CTRL fields -> bus word, unused bits zero
    function automatic logic [31:0] ctrl_encode(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]          = c.en;
        w[CTRL_MODE_BIT]        = c.mode;
        w[CTRL_MASK_BIT]        = c.mask;
        w[CTRL_ONESHOT_BIT]     = c.oneshot;
        w[CTRL_PRESC_LSB +: 8]  = c.presc;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_nch_if.sv
// apb_timer_nch_if: APB3 slave signals for the timer (no pready/pslverr).
// Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
// exactly one access cycle (psel=1, penable=1); the slave never stalls, so
// writes commit and read data is valid during the access cycle.
interface apb_timer_nch_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_timer_chan.sv
// apb_timer_chan: one down-counting timer channel with LOAD, CTRL, raw flag
// and one-cycle expiry trigger. Optional prescaler under TIMER_PRESCALER_EN.
module apb_timer_chan
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_we,
    input  logic [CNT_W-1:0] load_wdata,
    input  logic             ctrl_we,
    input  ctrl_t            ctrl_wdata,
    input  logic             eoi_clr,
    input  logic             etb_on,
    input  logic             etb_off,
    output logic [CNT_W-1:0] load_q,
    output logic [CNT_W-1:0] current_q,
    output ctrl_t            ctrl_q,
    output logic             raw_q,
    output logic             trig_q
);

    logic tick;
    logic expire;
    logic en_cmd;
    logic en_rise;

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc_cnt;

    // Prescaler: restart on any CTRL write or enable edge, idle while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (ctrl_we || en_rise || !ctrl_q.en || presc_cnt == ctrl_q.presc) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

    assign tick = (presc_cnt == ctrl_q.presc);
`else
    logic unused_presc;
    assign unused_presc = &{1'b0, ctrl_wdata.presc};
    assign tick = 1'b1;
`endif

    assign expire = ctrl_q.en && tick && (current_q == '0);

    // Next EN: APB write > ETB off > one-shot expiry > ETB on
    always_comb begin
        en_cmd = ctrl_q.en;
        if (ctrl_we) begin
            en_cmd = ctrl_wdata.en;
        end else if (etb_off) begin
            en_cmd = 1'b0;
        end else if (expire && ctrl_q.oneshot) begin
            en_cmd = 1'b0;
        end else if (etb_on) begin
            en_cmd = 1'b1;
        end
    end

    assign en_rise = en_cmd && !ctrl_q.en;

    // LOAD register; only sampled by the counter at start and reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= '0;
        end else if (load_we) begin
            load_q <= load_wdata;
        end
    end

    // CTRL register; EN also follows ETB pulses and one-shot expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q.en <= en_cmd;
            if (ctrl_we) begin
                ctrl_q.mode    <= ctrl_wdata.mode;
                ctrl_q.mask    <= ctrl_wdata.mask;
                ctrl_q.oneshot <= ctrl_wdata.oneshot;
`ifdef TIMER_PRESCALER_EN
                ctrl_q.presc   <= ctrl_wdata.presc;
`else
                ctrl_q.presc   <= '0;
`endif
            end
        end
    end

    // Counter: load on enable edge, then decrement and reload on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_q <= '0;
        end else if (en_rise) begin
            current_q <= load_q;
        end else if (ctrl_q.en && tick) begin
            if (current_q != '0) begin
                current_q <= current_q - 1'b1;
            end else if (ctrl_q.oneshot) begin
                current_q <= '0;
            end else if (ctrl_q.mode) begin
                current_q <= load_q;
            end else begin
                current_q <= '1;
            end
        end
    end

    // Raw flag: expiry wins over a same-cycle EOI clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
        end else if (expire) begin
            raw_q <= 1'b1;
        end else if (eoi_clr) begin
            raw_q <= 1'b0;
        end
    end

    // One-cycle registered trigger on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= expire;
        end
    end

endmodule

// File: rtl/apb_timer_nch.sv
// apb_timer_nch: NUM_CH-channel APB down-counting timer. Holds APB decode,
// the read mux and global status registers. TIMER_PRESCALER_EN enables the
// per-channel CTRL[15:8] prescaler.
module apb_timer_nch
    import apb_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_timer_nch_if.slave    apb,
    input  logic [NUM_CH-1:0] etb_trig_en_on,
    input  logic [NUM_CH-1:0] etb_trig_en_off,
    output logic [NUM_CH-1:0] etb_trig,
    output logic [NUM_CH-1:0] intr,
    input  logic              scan_mode
);

    logic              wr_acc;
    logic              rd_acc;
    logic              eoi_all;
    ctrl_t             ctrl_wdata;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] raw;
    logic [CNT_W-1:0]  load_q    [NUM_CH];
    logic [CNT_W-1:0]  current_q [NUM_CH];
    ctrl_t             ctrl_q    [NUM_CH];

    // scan_mode is DFT-only; upper pwdata bits may not be decoded
    logic unused_ok;
    assign unused_ok = &{1'b0, scan_mode, apb.pwdata};

    assign wr_acc     = apb.psel && apb.penable && apb.pwrite;
    assign rd_acc     = apb.psel && apb.penable && !apb.pwrite;
    assign eoi_all    = rd_acc && (apb.paddr == ADDR_EOI_ALL);
    assign ctrl_wdata = ctrl_decode(apb.pwdata);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        apb_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (pclk),
            .rst_n      (presetn),
            .load_we    (wr_acc && (apb.paddr == chan_addr(g, OFF_LOAD))),
            .load_wdata (apb.pwdata[CNT_W-1:0]),
            .ctrl_we    (wr_acc && (apb.paddr == chan_addr(g, OFF_CTRL))),
            .ctrl_wdata (ctrl_wdata),
            .eoi_clr    (eoi_all || (rd_acc && (apb.paddr == chan_addr(g, OFF_EOI)))),
            .etb_on     (etb_trig_en_on[g]),
            .etb_off    (etb_trig_en_off[g]),
            .load_q     (load_q[g]),
            .current_q  (current_q[g]),
            .ctrl_q     (ctrl_q[g]),
            .raw_q      (raw[g]),
            .trig_q     (etb_trig[g])
        );

        assign intr[g] = raw[g] && !ctrl_q[g].mask;
    end

    // Read mux; EOI registers and unmapped addresses read 0
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (apb.paddr == chan_addr(i, OFF_LOAD))    rdata = 32'(load_q[i]);
            if (apb.paddr == chan_addr(i, OFF_CURRENT)) rdata = 32'(current_q[i]);
            if (apb.paddr == chan_addr(i, OFF_CTRL))    rdata = ctrl_encode(ctrl_q[i]);
            if (apb.paddr == chan_addr(i, OFF_ISTAT))   rdata = 32'(intr[i]);
        end
        if (apb.paddr == ADDR_INTSTAT) rdata = 32'(intr);
        if (apb.paddr == ADDR_RAWSTAT) rdata = 32'(raw);
    end

    assign apb.prdata = rd_acc ? rdata : 32'd0;

endmodule
